// File: rtl/if_fetch_if.sv
// Instruction memory bus between the fetch unit (master) and instruction memory (slave).
//
// Handshake: the master raises inst_req with inst_addr and holds both unchanged
// until the rising edge at which the slave drives inst_ack=1 (with inst_rdata valid
// in that same cycle). A request is never withdrawn, and at most one is outstanding.
interface if_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_ack;
    logic [DATA_W-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_ack,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_ack,
        output inst_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch unit: sequential word fetches over a single-outstanding
// req/ack bus into a small prefetch FIFO whose head feeds IF/ID. Handles
// ID-stage branch redirects (delay slot kept) and exception flushes.
module if_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    if_fetch_if.master        mem,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic [1:0]        o_dbg_state
);
    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_req, w_req_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
    logic              r_pend, w_pend_nxt;
    logic [ADDR_W-1:0] r_tgt, w_tgt_nxt;

    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [DATA_W-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_ack, w_empty, w_can_pop, w_redir;
    logic              w_enq, w_pop, w_clear;
    logic [CNT_W-1:0]  w_cnt_pop, w_cnt_enq;
    logic [ADDR_W-1:0] w_seq_pc;
    logic              w_unused_stall;

    // Only the IF/ID hold bit of the pause vector matters here.
    assign w_unused_stall = ^{stall[5:2], stall[0]};

    assign w_ack     = mem.inst_ack & r_req;
    assign w_empty   = (r_count == '0);
    assign w_can_pop = ~stall[1] & ~w_empty;
    assign w_redir   = branch_flag_i & ~stall[1] & ~flush;
    assign w_cnt_pop = r_count - CNT_W'(w_can_pop);
    assign w_cnt_enq = w_cnt_pop + CNT_W'(1);
    assign w_seq_pc  = r_fetch_pc + ADDR_W'(4);

    assign mem.inst_req  = r_req;
    assign mem.inst_addr = r_addr;
    assign if_pc         = w_empty ? '0 : r_pc_mem[r_rd_ptr];
    assign if_inst       = w_empty ? '0 : r_inst_mem[r_rd_ptr];
    assign o_dbg_state   = r_state;

    // Next-state logic for the fetch FSM, bus request and redirect bookkeeping.
    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_addr_nxt     = r_addr;
        w_fetch_pc_nxt = r_fetch_pc;
        w_pend_nxt     = r_pend;
        w_tgt_nxt      = r_tgt;
        w_enq          = 1'b0;
        w_pop          = 1'b0;
        w_clear        = 1'b0;
        if (flush || (w_redir && !w_empty)) begin
            // Flush, or a branch whose delay slot is already at the head: the
            // head leaves (or is discarded), everything younger is dropped and
            // any response for the old stream is thrown away.
            w_clear        = 1'b1;
            w_pend_nxt     = 1'b0;
            w_fetch_pc_nxt = flush ? new_pc : branch_target_address_i;
            if (r_state != S_IDLE) begin
                if (w_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DROP;
                end
            end
        end else begin
            w_pop = w_can_pop;
            // Branch with an empty FIFO: the next old-stream word is the delay slot.
            if (w_redir) begin
                w_pend_nxt = 1'b1;
                w_tgt_nxt  = branch_target_address_i;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cnt_pop < FULL) begin
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = r_fetch_pc;
                        w_state_nxt = S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_ack) begin
                        w_enq          = 1'b1;
                        w_fetch_pc_nxt = w_pend_nxt ? w_tgt_nxt : w_seq_pc;
                        w_pend_nxt     = 1'b0;
                        if (w_cnt_enq < FULL) begin
                            w_addr_nxt = w_fetch_pc_nxt;
                        end else begin
                            w_req_nxt   = 1'b0;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (w_ack) begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM, bus outputs and fetch/redirect registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_fetch_pc <= RESET_PC;
            r_pend     <= 1'b0;
            r_tgt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_pend     <= w_pend_nxt;
            r_tgt      <= w_tgt_nxt;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_enq ? w_cnt_enq : w_cnt_pop;
        end
    end

    // FIFO storage; contents are only visible through the occupancy check.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc_mem[r_wr_ptr]   <= r_addr;
            r_inst_mem[r_wr_ptr] <= mem.inst_rdata;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a table of per-cycle vectors for the streaming
// and full-FIFO cases, then hand-written sequences for redirect, flush and reset.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] br_tgt = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;
    int wait_cnt = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        rst_before;
        logic        st1;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[$];

    if_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    if_fetch dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag),
        .branch_target_address_i (br_tgt),
        .mem                     (bus),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst),
        .o_dbg_state             (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Instruction memory: acks a request in its mem_lat-th cycle.
    always @(negedge clk) begin
        if (bus.inst_req) begin
            if (wait_cnt >= mem_lat - 1) begin
                bus.inst_ack   = 1'b1;
                bus.inst_rdata = mem_word(bus.inst_addr);
                wait_cnt       = 0;
            end else begin
                bus.inst_ack   = 1'b0;
                bus.inst_rdata = '0;
                wait_cnt       = wait_cnt + 1;
            end
        end else begin
            bus.inst_ack   = 1'b0;
            bus.inst_rdata = '0;
            wait_cnt       = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic st1);
        rst         = 1'b0;
        stall       = {4'b0, st1, 1'b0};
        flush       = 1'b0;
        branch_flag = 1'b0;
        tick();
        tick();
        check("rst_req", 32'(bus.inst_req), 32'h0);
        check("rst_addr", bus.inst_addr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (bus.inst_req !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("wait_req_timeout", 32'(bus.inst_req), 32'h1);
    endtask

    task automatic wait_deliver(input int budget);
        int n = 0;
        while (if_inst === 32'h0 && n < budget) begin
            tick();
            n++;
        end
        check("wait_deliver_timeout", 32'(if_inst != 32'h0), 32'h1);
    endtask

    function automatic void add(input logic rb, input logic s, input logic r,
                                input logic [31:0] a, input logic [31:0] p, input logic [31:0] i);
        vec_t v;
        v.rst_before = rb;
        v.st1        = s;
        v.exp_req    = r;
        v.exp_addr   = a;
        v.exp_pc     = p;
        v.exp_inst   = i;
        vecs.push_back(v);
    endfunction

    initial begin
        int n;

        // Zero-wait streaming: one fetch per cycle, head one cycle behind each ack.
        add(1, 0, 1, 32'h00, 32'h0, 32'h0);
        add(0, 0, 1, 32'h04, 32'h0, mem_word(32'h0));
        add(0, 0, 1, 32'h08, 32'h4, mem_word(32'h4));
        add(0, 0, 1, 32'h0C, 32'h8, mem_word(32'h8));
        add(0, 0, 1, 32'h10, 32'hC, mem_word(32'hC));
        // IF/ID held: four fetches fill the FIFO, then no request until a pop.
        add(1, 1, 1, 32'h00, 32'h0, 32'h0);
        add(0, 1, 1, 32'h04, 32'h0, mem_word(32'h0));
        add(0, 1, 1, 32'h08, 32'h0, mem_word(32'h0));
        add(0, 1, 1, 32'h0C, 32'h0, mem_word(32'h0));
        for (int k = 0; k < 5; k++) add(0, 1, 0, 32'h0, 32'h0, mem_word(32'h0));
        add(0, 0, 0, 32'h0, 32'h0, mem_word(32'h0));
        add(0, 0, 1, 32'h10, 32'h4, mem_word(32'h4));
        add(0, 0, 1, 32'h14, 32'h8, mem_word(32'h8));
        add(0, 0, 1, 32'h18, 32'hC, mem_word(32'hC));
        add(0, 0, 1, 32'h1C, 32'h10, mem_word(32'h10));

        mem_lat = 1;
        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].rst_before) do_reset(vecs[v].st1);
            check($sformatf("vec%0d_req", v), 32'(bus.inst_req), 32'(vecs[v].exp_req));
            if (vecs[v].exp_req) check($sformatf("vec%0d_addr", v), bus.inst_addr, vecs[v].exp_addr);
            check($sformatf("vec%0d_if_pc", v), if_pc, vecs[v].exp_pc);
            check($sformatf("vec%0d_if_inst", v), if_inst, vecs[v].exp_inst);
            stall[1] = vecs[v].st1;
            tick();
        end

        // Branch with head 0x8, 0xC queued, 0x10 in flight (3-cycle memory).
        mem_lat = 3;
        do_reset(1'b1);
        n = 0;
        while (bus.inst_req !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check("t3_full_req_low", 32'(bus.inst_req), 32'h0);
        check("t3_full_head", if_pc, 32'h0);
        stall[1] = 1'b0;
        tick();
        check("t3_reissue_req", 32'(bus.inst_req), 32'h1);
        check("t3_reissue_addr", bus.inst_addr, 32'h10);
        tick();
        check("t3_head_pc", if_pc, 32'h8);
        check("t3_head_inst", if_inst, mem_word(32'h8));
        check("t3_no_ack_yet", 32'(bus.inst_ack), 32'h0);
        branch_flag = 1'b1;
        br_tgt      = 32'h100;
        tick();
        branch_flag = 1'b0;
        check("t3_cleared_pc", if_pc, 32'h0);
        check("t3_cleared_inst", if_inst, 32'h0);
        check("t3_drop_req_held", 32'(bus.inst_req), 32'h1);
        check("t3_drop_addr_held", bus.inst_addr, 32'h10);
        check("t3_drop_state", 32'(dbg_state), 32'h2);
        tick();
        wait_req(10);
        check("t3_target_addr", bus.inst_addr, 32'h100);
        wait_deliver(10);
        check("t3_first_after_pc", if_pc, 32'h100);
        check("t3_first_after_inst", if_inst, mem_word(32'h100));

        // Empty FIFO, 0x24 outstanding, branch to 0x200: 0x24 kept as delay slot.
        flush  = 1'b1;
        new_pc = 32'h24;
        tick();
        flush = 1'b0;
        check("t4_flush_empty", if_pc, 32'h0);
        n = 0;
        while (!(bus.inst_req === 1'b1 && bus.inst_addr === 32'h24) && n < 20) begin
            tick();
            n++;
        end
        check("t4_req_0x24", bus.inst_addr, 32'h24);
        branch_flag = 1'b1;
        br_tgt      = 32'h200;
        tick();
        branch_flag = 1'b0;
        check("t4_still_empty", if_inst, 32'h0);
        exp_q.push_back(32'h24);
        exp_q.push_back(32'h200);
        for (int k = 0; k < 2; k++) begin
            logic [31:0] exp_pc;
            wait_deliver(10);
            exp_pc = exp_q.pop_front();
            check($sformatf("t4_deliver%0d_pc", k), if_pc, exp_pc);
            check($sformatf("t4_deliver%0d_inst", k), if_inst, mem_word(exp_pc));
            if (k == 0) check("t4_next_req_addr", bus.inst_addr, 32'h200);
            tick();
        end

        // Flush coincident with an ack and a branch: flush wins, ack discarded.
        stall[1] = 1'b1;
        n = 0;
        while (!(bus.inst_ack === 1'b1 && if_inst !== 32'h0) && n < 30) begin
            tick();
            n++;
        end
        check("t5_ack_with_data", 32'(bus.inst_ack), 32'h1);
        flush       = 1'b1;
        new_pc      = 32'h180;
        branch_flag = 1'b1;
        br_tgt      = 32'h300;
        stall[1]    = 1'b0;
        tick();
        flush       = 1'b0;
        branch_flag = 1'b0;
        check("t5_empty_pc", if_pc, 32'h0);
        check("t5_empty_inst", if_inst, 32'h0);
        check("t5_req_low", 32'(bus.inst_req), 32'h0);
        wait_req(5);
        check("t5_new_addr", bus.inst_addr, 32'h180);
        wait_deliver(10);
        check("t5_deliver_pc", if_pc, 32'h180);

        // Asynchronous reset in the middle of a request.
        stall[1] = 1'b1;
        n = 0;
        while (!(bus.inst_req === 1'b1 && if_inst !== 32'h0) && n < 30) begin
            tick();
            n++;
        end
        check("t6_pre_req", 32'(bus.inst_req), 32'h1);
        rst = 1'b0;
        #1;
        check("t6_async_req", 32'(bus.inst_req), 32'h0);
        check("t6_async_addr", bus.inst_addr, 32'h0);
        check("t6_async_pc", if_pc, 32'h0);
        check("t6_async_inst", if_inst, 32'h0);
        mem_lat  = 1;
        stall[1] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t6_restart_req", 32'(bus.inst_req), 32'h1);
        check("t6_restart_addr", bus.inst_addr, 32'h0);
        tick();
        check("t6_second_addr", bus.inst_addr, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit with a small prefetch queue, directly upstream of the IF/ID pipeline register. It issues sequential word fetches to instruction memory over a single-outstanding req/ack bus and buffers the returned instructions in a FIFO. Each cycle it presents the FIFO head as `if_pc`/`if_inst` to IF/ID. It redirects on ID-stage branches, preserving the delay slot, and on pipeline flush (exceptions).

## Interface
- `ADDR_W`, 32, instruction address width
- `DATA_W`, 32, instruction word width
- `DEPTH`, 4, prefetch FIFO entries (power of 2, ≥2)
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
---
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `stall`  in  6  ctrl pause vector; only `stall[1]` used (1 = IF/ID holds, no pop)
- `flush`  in  1  exception flush, 1 = discard everything
- `new_pc`  in  ADDR_W  restart address on flush
- `branch_flag_i`  in  1  ID resolved taken branch/jump
- `branch_target_address_i`  in  ADDR_W  branch target
- `inst_req`  out  1  fetch request (registered)
- `inst_addr`  out  ADDR_W  fetch address (registered)
- `inst_ack`  in  1  memory response valid for the current request
- `inst_rdata`  in  DATA_W  instruction word, valid with `inst_ack`
- `if_pc`  out  ADDR_W  head PC to IF/ID; 0 when FIFO empty
- `if_inst`  out  DATA_W  head instruction to IF/ID; 0 (nop) when FIFO empty

## Operation
- Registers: `fetch_pc`, FIFO (pc+inst per entry, rd/wr pointers, count 0..DEPTH), FSM {IDLE, REQ, DROP}, `pend` + `tgt` (deferred redirect).
- Bus rule: `inst_req`/`inst_addr` stay stable from assertion until the edge where `inst_ack`=1. Requests are never withdrawn. At most one request is outstanding.
- IDLE: if count<DEPTH, assert `inst_req` with `inst_addr`=`fetch_pc` next cycle → REQ.
- REQ, ack: enqueue {inst_addr, inst_rdata}. `fetch_pc`+=4 (mod 2^ADDR_W, wraps). If count after this edge < DEPTH, stay in REQ with the new address; else → IDLE, req low.
- DROP: request is held until ack, then the response is discarded and the block → IDLE.
- Pop: when `stall[1]`=0 and FIFO non-empty, head is removed at the edge. Enqueue and pop can occur in the same edge; count is unchanged.
- Redirect (`branch_flag_i`=1, `stall[1]`=0, `flush`=0):
  - FIFO non-empty: head is popped as the delay slot. All other entries are cleared. Any in-flight response, including one acking this cycle, is discarded. An un-acked request → DROP. `fetch_pc`←target.
  - FIFO empty: set `pend`, `tgt`←target. The next old-stream response is enqueued as the delay slot. At that ack edge, `fetch_pc`←`tgt` and `pend` clears. No further old-stream request is issued.
  - `branch_flag_i` with `stall[1]`=1 is ignored. It is re-presented after the stall.
- Flush: highest priority over redirect, pop and enqueue. FIFO cleared, `pend` cleared, `fetch_pc`←`new_pc`. An un-acked request → DROP; an ack in the flush cycle is discarded.
- Branch in a delay slot: unsupported, behaviour undefined.

## Timing
- Reset (async, `rst`=0): `inst_req`=0, `inst_addr`=0, FIFO empty, `if_pc`=0, `if_inst`=0, state IDLE, `fetch_pc`=RESET_PC, `pend`=0. A request in flight at reset is abandoned; memory must tolerate this.
- First `inst_req` is high in the first cycle after the first edge with `rst`=1.
- Zero-wait memory (ack in the request's first cycle): 1 instruction/cycle sustained. Enqueued data is visible on `if_pc`/`if_inst` the cycle after the ack edge.
- `if_pc`/`if_inst` are combinational from the FIFO head register and stable while `stall[1]`=1.
- Full: no request issued while count=DEPTH; issue resumes in the cycle after a pop.
- Flush-to-first-request at `new_pc`: 1 cycle if idle; ack-of-dropped + 1 cycle otherwise.

## Test plan
- Reset, zero-wait memory, `stall`=0 → `inst_addr` 0,4,8,… on consecutive cycles; `if_pc` 0,4,8 one cycle behind each ack.
- `stall[1]`=1 for 10 cycles, zero-wait memory → exactly 4 fetches (0x0–0xC), `inst_req` low, `if_pc`=0 held. Release → pops 0,4,8,C, fetch resumes at 0x10.
- Head pc 0x8, branch_flag with target 0x100 while 0xC queued and 0x10 in flight with 3-cycle ack → 0x8 delivered, 0xC dropped, 0x10 ack discarded, next `inst_addr`=0x100.
- FIFO empty, request 0x24 outstanding, branch to 0x200 → 0x24 enqueued and delivered as delay slot, next request 0x200.
- `flush`=1 with `new_pc`=0x180 coincident with ack and branch_flag → FIFO empty next cycle, ack discarded, next `inst_addr`=0x180.
- `rst` low mid-request (`inst_req`=1) → `inst_req`, `if_pc`, `if_inst` = 0 immediately. After release, fetch restarts at RESET_PC.
